multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit processor. Opcode is in inst[3:0]; the immediate field is decoded by the registered immediate generator.
- Sequences fetch, decode, execute, memory and writeback. Drives the PC, IR, memory, register file, ALU mux and ALU-op controls.
- Inserts memory wait states, flags illegal opcodes, and emits one retire pulse per completed instruction.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters HALT; 0 = illegal opcode retires as NOP.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  4  IR[3:0]; stable except in the cycle ir_write fires
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 PC+imm branch target, 10 register A
- ir_write  out  1  IR load enable
- iord  out  1  memory address: 0 PC, 1 ALU out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- wb_sel  out  1  0 ALU out, 1 memory data
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 2, 10 immediate
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASSB
- retire  out  1  1-cycle pulse on an instruction's final cycle
- halted  out  1  high in HALT
- state_o  out  3  current state, for debug

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR (R-type)
  - 0101 LUI, 0110 BEQ, 0111 JR
  - 1000 ADDI, 1001 ORI, 1010 LW, 1011 SW
  - 0100 and 11xx are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset: state=FETCH immediately; all outputs are Moore-decoded, so all outputs are 0 while reset is held except the FETCH defaults. Reset asserted mid-instruction aborts it, with no retire and no writes after the edge.
- Outputs default to 0. mem_read/mem_write are level requests held across wait cycles.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE. Otherwise stay in FETCH with no writes.
- DECODE: no strobes. The immediate generator samples the IR at the end of this cycle, so the immediate is valid from EXEC. Next state is EXEC, or for an illegal opcode: HALT (HALT_ON_ILLEGAL=1) or FETCH with retire=1 (HALT_ON_ILLEGAL=0).
- EXEC, by opcode:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op={0,opcode[1:0]}; next WB.
  - LUI: alu_src_b=10, alu_op=PASSB; next WB.
  - ADDI/LW/SW: alu_src_a=1, alu_src_b=10, alu_op=ADD. ADDI goes to WB; LW/SW go to MEM.
  - ORI: same muxes, alu_op=OR; next WB.
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero, retire=1; next FETCH.
  - JR: pc_src=10, pc_write=1, retire=1; next FETCH.
- MEM: iord=1; mem_read=1 for LW, mem_write=1 for SW. Stay in MEM until mem_ready=1. On mem_ready: LW goes to WB; SW sets retire=1 and goes to FETCH.
- WB: reg_write=1, wb_sel=1 for LW and 0 otherwise, retire=1; next FETCH.
- HALT: halted=1, all strobes 0, absorbing until reset.
- mem_ready is ignored outside FETCH/MEM.
- Latency in cycles, with no wait states:
  - R-type/LUI/ADDI/ORI: 4
  - LW: 5
  - SW: 4
  - BEQ/JR: 3
  - Each mem_ready=0 cycle adds 1.

Decomposition:
- Shared package (proc_ctrl_pkg) holds:
  - opcode constants
  - state enum
  - alu_op, pc_src and alu_src_b encodings
- One sub-module, ctrl_out_decode: purely combinational map from (state, opcode, zero, mem_ready) to the output strobes. Next-state logic and the state register live in the top module.

Test Plan:
- Reset while in MEM with mem_write=1 -> same cycle: state_o=0, mem_write=0, mem_read=1; no retire.
- ADD (opcode 0000), mem_ready always 1 -> states 0,1,2,4 → alu_op=000 in EXEC; reg_write=1, wb_sel=0, retire=1 in cycle 4.
- LW (1010) with mem_ready low 2 cycles in MEM -> states 0,1,2,3,3,3,4 → mem_read=1, iord=1 held throughout MEM; wb_sel=1 in WB; 7 cycles total.
- BEQ (0110): zero=1 -> pc_write=1, pc_src=01 in EXEC. Repeat with zero=0 -> pc_write=0. Both cases retire in cycle 3.
- FETCH with mem_ready=0 for 3 cycles -> ir_write and pc_write stay 0 until the 4th cycle, then pulse exactly once.
- Illegal opcode 1100:
  - HALT_ON_ILLEGAL=1 -> state 5, halted=1, persists 10 cycles until reset.
  - HALT_ON_ILLEGAL=0 -> retire in DECODE, next state FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// mux/ALU selects and the bundled strobe record produced by the output decoder.
package proc_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JR   = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_ORI  = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_SW   = 4'b1011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REGA   = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_TWO  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       retire;
    logic       halted;
  } ctrl_t;

  // 0100 and the whole 11xx block are unassigned.
  function automatic logic is_legal(input logic [3:0] op);
    return !((op == 4'b0100) || (op[3:2] == 2'b11));
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       retire;
  logic       halted;
  logic [2:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, retire, halted, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op, retire, halted, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm_ctrl_out_decode.sv
// Combinational strobe decode from the current state plus the few live inputs
// (opcode, ALU zero, memory ready) that qualify them.
module ctrl_out_decode
  import proc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        if (mem_ready_i) begin
          ctrl_o.ir_write = 1'b1;
          ctrl_o.pc_write = 1'b1;
          ctrl_o.pc_src   = PC_ALU;
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode_i) && !HALT_ON_ILLEGAL) ctrl_o.retire = 1'b1;
      end
      ST_EXEC: begin
        case (opcode_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REGB;
            ctrl_o.alu_op    = {1'b0, opcode_i[1:0]};
          end
          OP_LUI: begin
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_PASSB;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
          end
          OP_ORI: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_OR;
          end
          OP_BEQ: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REGB;
            ctrl_o.alu_op    = ALU_SUB;
            ctrl_o.pc_src    = PC_BRANCH;
            ctrl_o.pc_write  = zero_i;
            ctrl_o.retire    = 1'b1;
          end
          OP_JR: begin
            ctrl_o.pc_src   = PC_REGA;
            ctrl_o.pc_write = 1'b1;
            ctrl_o.retire   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Requests are levels held across every wait cycle.
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_read  = (opcode_i == OP_LW);
        ctrl_o.mem_write = (opcode_i == OP_SW);
        ctrl_o.retire    = mem_ready_i && (opcode_i == OP_SW);
      end
      ST_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.wb_sel    = (opcode_i == OP_LW);
        ctrl_o.retire    = 1'b1;
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer: state register and next-state logic; strobes come
// from the combinational output decoder.
module multicycle_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  multicycle_control_fsm_if.master   bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // Masking mem_ready while reset is held keeps FETCH from pulsing ir/pc writes.
  ctrl_out_decode #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_dec (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready & ~reset),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_legal(bus.opcode)) state_d = ST_EXEC;
        else                      state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
      end
      ST_EXEC: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = ST_MEM;
          OP_BEQ, OP_JR:  state_d = ST_FETCH;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM:    if (bus.mem_ready) state_d = (bus.opcode == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign bus.pc_write  = ctrl.pc_write;
  assign bus.pc_src    = ctrl.pc_src;
  assign bus.ir_write  = ctrl.ir_write;
  assign bus.iord      = ctrl.iord;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.wb_sel    = ctrl.wb_sel;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.retire    = ctrl.retire;
  assign bus.halted    = ctrl.halted;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multi-cycle control unit: two instances (halt / retire-as-NOP on
// illegal opcodes) driven in lockstep against per-instruction expected traces.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;

  always #5 clk = ~clk;

  multicycle_control_fsm_if if1 ();
  multicycle_control_fsm_if if0 ();

  assign if1.opcode = opcode;    assign if0.opcode = opcode;
  assign if1.zero = zero;        assign if0.zero = zero;
  assign if1.mem_ready = mem_ready; assign if0.mem_ready = mem_ready;

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clock(clk), .reset(rst), .bus(if1));
  multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut0 (.clock(clk), .reset(rst), .bus(if0));

  logic [19:0] obs1, obs0;
  assign obs1 = {if1.state_o, if1.pc_write, if1.pc_src, if1.ir_write, if1.iord, if1.mem_read,
                 if1.mem_write, if1.reg_write, if1.wb_sel, if1.alu_src_a, if1.alu_src_b,
                 if1.alu_op, if1.retire, if1.halted};
  assign obs0 = {if0.state_o, if0.pc_write, if0.pc_src, if0.ir_write, if0.iord, if0.mem_read,
                 if0.mem_write, if0.reg_write, if0.wb_sel, if0.alu_src_a, if0.alu_src_b,
                 if0.alu_op, if0.retire, if0.halted};

  int n_cmp = 0;
  int n_fail = 0;

  logic        q_mr[$];
  logic [19:0] q_e1[$];
  logic [19:0] q_e0[$];

  logic [3:0] legal_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

  function automatic logic [19:0] mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic io, input logic mr, input logic mw,
                                     input logic rw, input logic wb, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic ret, input logic hlt);
    return {st, pcw, pcs, irw, io, mr, mw, rw, wb, asa, asb, aop, ret, hlt};
  endfunction

  function automatic logic [19:0] fetch_exp(input logic fin);
    return mk(3'd0, fin, 2'b00, fin, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
  endfunction

  function automatic void push(input logic mr, input logic [19:0] e1, input logic [19:0] e0);
    q_mr.push_back(mr); q_e1.push_back(e1); q_e0.push_back(e0);
  endfunction

  task automatic check_now(input string nm, input logic [19:0] e1, input logic [19:0] e0);
    n_cmp++;
    if (obs1 !== e1) begin
      n_fail++;
      $display("FAIL %s halt_dut t=%0t got %b required %b", nm, $time, obs1, e1);
    end
    n_cmp++;
    if (obs0 !== e0) begin
      n_fail++;
      $display("FAIL %s nop_dut t=%0t got %b required %b", nm, $time, obs0, e0);
    end
  endtask

  // Expected per-cycle trace of one instruction, built from the instruction's
  // phase list: fetch (with waits), decode, execute, memory (with waits), writeback.
  task automatic gen(input logic [3:0] op, input logic z, input int fw, input int mwt);
    logic [19:0] e, d1, d0;
    logic is_ld, is_st;
    is_ld = (op == 4'hA);
    is_st = (op == 4'hB);
    for (int i = 0; i < fw; i++) push(1'b0, fetch_exp(1'b0), fetch_exp(1'b0));
    push(1'b1, fetch_exp(1'b1), fetch_exp(1'b1));
    d1 = mk(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    if (op == 4'b0100 || op[3:2] == 2'b11) begin
      d0 = mk(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
      push(1'($urandom_range(0, 1)), d1, d0);
      for (int i = 0; i < 10; i++)
        push(1'b0, mk(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1), fetch_exp(1'b0));
      return;
    end
    push(1'($urandom_range(0, 1)), d1, d1);
    if (op < 4'd4)       e = mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, {1'b0, op[1:0]}, 0, 0);
    else if (op == 4'd5) e = mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b100, 0, 0);
    else if (op == 4'd6) e = mk(3'd2, z, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1, 0);
    else if (op == 4'd7) e = mk(3'd2, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
    else if (op == 4'd9) e = mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011, 0, 0);
    else                 e = mk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0);
    push(1'($urandom_range(0, 1)), e, e);
    if (op == 4'd6 || op == 4'd7) return;
    if (is_ld || is_st) begin
      e = mk(3'd3, 0, 2'b00, 0, 1, is_ld, is_st, 0, 0, 0, 2'b00, 3'b000, 0, 0);
      for (int i = 0; i < mwt; i++) push(1'b0, e, e);
      e[1] = is_st;
      push(1'b1, e, e);
      if (is_st) return;
    end
    e = mk(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, is_ld, 0, 2'b00, 3'b000, 1, 0);
    push(1'($urandom_range(0, 1)), e, e);
  endtask

  task automatic run_q(input string nm, input int n);
    int k = 0;
    while (q_mr.size() > 0 && (n < 0 || k < n)) begin
      logic [19:0] e1, e0;
      mem_ready = q_mr.pop_front();
      e1 = q_e1.pop_front();
      e0 = q_e0.pop_front();
      @(negedge clk);
      check_now($sformatf("%s_c%0d", nm, k), e1, e0);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic clear_q();
    q_mr.delete(); q_e1.delete(); q_e0.delete();
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_now({nm, "_assert"}, fetch_exp(1'b0), fetch_exp(1'b0));
    @(posedge clk); #1;
    check_now({nm, "_held"}, fetch_exp(1'b0), fetch_exp(1'b0));
    rst = 1'b0;
  endtask

  task automatic run_instr(input string nm, input logic [3:0] op, input logic z,
                           input int fw, input int mwt);
    opcode = op;
    zero = z;
    gen(op, z, fw, mwt);
    run_q(nm, -1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_now("reset_state", fetch_exp(1'b0), fetch_exp(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    opcode = 4'hB;
    zero = 1'b0;
    gen(4'hB, 1'b0, 0, 3);
    run_q("sw_pre", 4);
    mem_ready = 1'b1;
    #1;
    check_now("sw_mem_pending", mk(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0),
              mk(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0));
    clear_q();
    do_reset("reset_mid_mem");
    run_instr("add_after_abort", 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_basic();
    run_instr("add", 4'h0, 1'b0, 0, 0);
    run_instr("lw_wait2", 4'hA, 1'b0, 0, 2);
    run_instr("beq_taken", 4'h6, 1'b1, 0, 0);
    run_instr("beq_not_taken", 4'h6, 1'b0, 0, 0);
    run_instr("fetch_wait3", 4'h1, 1'b0, 3, 0);
    run_instr("jr", 4'h7, 1'b0, 1, 0);
    run_instr("lui", 4'h5, 1'b0, 0, 0);
    run_instr("sw_nowait", 4'hB, 1'b0, 0, 0);
  endtask

  task automatic test_illegal(input logic [3:0] op, input string nm);
    run_instr(nm, op, 1'b0, 1, 0);
    do_reset({nm, "_reset"});
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = legal_ops[$urandom_range(0, 10)];
      run_instr($sformatf("rand%0d_op%0h", i, op), op, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 4'h0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid_mem();
    test_illegal(4'b1100, "illegal_1100");
    test_illegal(4'b0100, "illegal_0100");
    test_back_to_back();
    test_illegal(4'b1111, "illegal_1111");
    run_instr("ori_after_reset", 4'h9, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
